// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: single-command I2C master (0-3 byte write, repeated START, 0-2 byte read)
// driving open-drain SCL/SDA, with quarter-bit timing and clock-stretch support.
module i2c_cmd_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic       nack,
    input  logic [6:0] addr,
    input  logic [1:0] num_wr_bytes,
    input  logic [7:0] wr_data0,
    input  logic [7:0] wr_data1,
    input  logic [7:0] wr_data2,
    input  logic [1:0] num_rd_bytes,
    output logic [7:0] rd_data0,
    output logic [7:0] rd_data1,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_t,
    output logic       sda_t
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_SEND_BYTE, S_GET_ACK, S_RECV_BYTE,
        S_SEND_ACK, S_RSTART, S_STOP, S_FINISH
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [1:0]      r_q;
    logic [6:0]      r_addr;
    logic [1:0]      r_nwr, r_nrd, r_idx;
    logic [7:0]      r_wd0, r_wd1, r_wd2, r_shift, r_rd0, r_rd1;
    logic [2:0]      r_bit;
    logic            r_rd_phase, r_ack, r_done, r_busy, r_nack, r_scl_t, r_sda_t;
    logic            w_stretch, w_tick, w_bit_end, w_last, w_scl_t, w_sda_t, w_rd_only;

    always_comb begin
        w_stretch = r_scl_t && !scl_i;
        w_tick    = r_state != S_IDLE && r_state != S_FINISH && !w_stretch && r_div == DIV_MAX;
        w_bit_end = w_tick && r_q == 2'd3;
        w_last    = r_idx == r_nrd - 2'd1;
        w_rd_only = num_wr_bytes == 2'd0 && num_rd_bytes != 2'd0;
        w_scl_t   = r_state inside {S_IDLE, S_START, S_FINISH} || r_q != 2'd0;
        w_sda_t   = r_state == S_SEND_BYTE ? r_shift[7] :
                    r_state == S_SEND_ACK  ? w_last :
                    r_state inside {S_START, S_RSTART} ? r_q < 2'd2 :
                    r_state == S_STOP      ? r_q >= 2'd2 : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_q        <= '0;
            r_addr     <= '0;
            r_nwr      <= '0;
            r_nrd      <= '0;
            r_idx      <= '0;
            r_wd0      <= '0;
            r_wd1      <= '0;
            r_wd2      <= '0;
            r_shift    <= '0;
            r_rd0      <= '0;
            r_rd1      <= '0;
            r_bit      <= '0;
            r_rd_phase <= 1'b0;
            r_ack      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_nack     <= 1'b0;
            r_scl_t    <= 1'b1;
            r_sda_t    <= 1'b1;
        end else begin
            r_scl_t <= w_scl_t;
            // SDA is held for the first cycle of Q0 so it never moves on the same cycle SCL falls
            r_sda_t <= (r_q == 2'd0 && r_div == '0) ? r_sda_t : w_sda_t;
            r_done  <= 1'b0;
            if (!w_stretch) r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) r_q <= r_q + 2'd1;
            case (r_state)
                S_IDLE: begin
                    if (start && !r_done) begin
                        r_state    <= S_START;
                        r_busy     <= 1'b1;
                        r_nack     <= 1'b0;
                        r_addr     <= addr;
                        r_nwr      <= num_wr_bytes;
                        r_nrd      <= num_rd_bytes == 2'd3 ? 2'd2 : num_rd_bytes;
                        r_wd0      <= wr_data0;
                        r_wd1      <= wr_data1;
                        r_wd2      <= wr_data2;
                        r_rd_phase <= w_rd_only;
                        r_shift    <= {addr, w_rd_only};
                        r_idx      <= '0;
                        r_bit      <= '0;
                        r_div      <= '0;
                        r_q        <= '0;
                    end
                end
                S_START, S_RSTART: if (w_bit_end) r_state <= S_SEND_BYTE;
                S_SEND_BYTE: begin
                    if (w_bit_end) begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= S_GET_ACK;
                    end
                end
                S_GET_ACK: begin
                    if (w_tick && r_q == 2'd2) r_ack <= sda_i;
                    if (w_bit_end) begin
                        if (r_ack) begin
                            r_nack  <= 1'b1;
                            r_state <= S_STOP;
                        end else if (r_rd_phase) begin
                            r_idx   <= '0;
                            r_state <= S_RECV_BYTE;
                        end else if (r_idx < r_nwr) begin
                            r_shift <= r_idx == 2'd0 ? r_wd0 : r_idx == 2'd1 ? r_wd1 : r_wd2;
                            r_idx   <= r_idx + 2'd1;
                            r_state <= S_SEND_BYTE;
                        end else if (r_nrd != 2'd0) begin
                            r_rd_phase <= 1'b1;
                            r_shift    <= {r_addr, 1'b1};
                            r_state    <= S_RSTART;
                        end else begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_RECV_BYTE: begin
                    if (w_tick && r_q == 2'd2) r_shift <= {r_shift[6:0], sda_i};
                    if (w_bit_end) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_SEND_ACK;
                            if (r_idx == 2'd0) r_rd0 <= r_shift;
                            else r_rd1 <= r_shift;
                        end
                    end
                end
                S_SEND_ACK: begin
                    if (w_bit_end) begin
                        if (w_last) r_state <= S_STOP;
                        else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= S_RECV_BYTE;
                        end
                    end
                end
                S_STOP: if (w_bit_end) r_state <= S_FINISH;
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done     = r_done;
    assign busy     = r_busy;
    assign nack     = r_nack;
    assign rd_data0 = r_rd0;
    assign rd_data1 = r_rd1;
    assign scl_t    = r_scl_t;
    assign sda_t    = r_sda_t;
endmodule
